// File: rtl/tl45_register_read.sv
// tl45_register_read: operand fetch with register file, bypass network and ALU operand buffer
module tl45_register_read #(
  parameter int XLEN = 32,
  parameter int NREG = 16
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_pipe_stall,
  input  logic            i_pipe_flush,
  output logic            o_pipe_stall,
  output logic            o_pipe_flush,
  input  logic [4:0]      i_opcode,
  input  logic [3:0]      i_dr,
  input  logic [3:0]      i_sr1,
  input  logic [3:0]      i_sr2,
  input  logic [XLEN-1:0] i_imm,
  input  logic            i_imm_valid,
  input  logic [3:0]      i_jmp_cond,
  input  logic [XLEN-1:0] i_pc,
  input  logic [3:0]      i_of_reg,
  input  logic [XLEN-1:0] i_of_val,
  input  logic [3:0]      i_wb_reg,
  input  logic [XLEN-1:0] i_wb_val,
  output logic [4:0]      o_opcode,
  output logic [3:0]      o_dr,
  output logic [3:0]      o_jmp_cond,
  output logic [XLEN-1:0] o_sr1_val,
  output logic [XLEN-1:0] o_sr2_val,
  output logic [XLEN-1:0] o_target_offset,
  output logic [XLEN-1:0] o_pc
);
  typedef struct packed {
    logic [4:0]      opcode;
    logic [3:0]      dr;
    logic [3:0]      jmp_cond;
    logic [XLEN-1:0] sr1_val;
    logic [XLEN-1:0] sr2_val;
    logic [XLEN-1:0] target_offset;
    logic [XLEN-1:0] pc;
  } buf_t;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [XLEN-1:0] sr1_res, sr2_res;
  buf_t buf_q, buf_d, ld;
  // Writeback is never gated by stall/flush; r0 is never written so it stays zero.
  always_comb begin
    rf_d = rf_q;
    if (i_wb_reg != 4'd0) rf_d[i_wb_reg] = i_wb_val;
  end
  // Operand resolution: r0, then ALU forward, then same-cycle writeback, then regfile.
  always_comb begin
    sr1_res = (i_sr1 == 4'd0) ? '0 : (i_sr1 == i_of_reg) ? i_of_val : (i_sr1 == i_wb_reg) ? i_wb_val : rf_q[i_sr1];
    sr2_res = (i_sr2 == 4'd0) ? '0 : (i_sr2 == i_of_reg) ? i_of_val : (i_sr2 == i_wb_reg) ? i_wb_val : rf_q[i_sr2];
  end
  // Operand buffer next state: flush to NOP beats stall-hold beats load.
  always_comb begin
    ld.opcode        = i_opcode;
    ld.dr            = i_dr;
    ld.jmp_cond      = i_jmp_cond;
    ld.sr1_val       = sr1_res;
    ld.sr2_val       = i_imm_valid ? i_imm : sr2_res;
    ld.target_offset = i_imm;
    ld.pc            = i_pc;
    buf_d = i_pipe_flush ? '0 : i_pipe_stall ? buf_q : ld;
  end
  // State registers with asynchronous clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rf_q  <= '{default: '0};
      buf_q <= '0;
    end else begin
      rf_q  <= rf_d;
      buf_q <= buf_d;
    end
  end
  assign o_pipe_stall    = i_pipe_stall;
  assign o_pipe_flush    = i_pipe_flush;
  assign o_opcode        = buf_q.opcode;
  assign o_dr            = buf_q.dr;
  assign o_jmp_cond      = buf_q.jmp_cond;
  assign o_sr1_val       = buf_q.sr1_val;
  assign o_sr2_val       = buf_q.sr2_val;
  assign o_target_offset = buf_q.target_offset;
  assign o_pc            = buf_q.pc;
endmodule

// File: tb/tb_tl45_register_read.sv
// tb_tl45_register_read: directed self-checking bench for tl45_register_read
module tb_tl45_register_read;
  logic        i_clk, i_reset, i_pipe_stall, i_pipe_flush, o_pipe_stall, o_pipe_flush;
  logic [4:0]  i_opcode, o_opcode;
  logic [3:0]  i_dr, i_sr1, i_sr2, i_jmp_cond, i_of_reg, i_wb_reg, o_dr, o_jmp_cond;
  logic [31:0] i_imm, i_pc, i_of_val, i_wb_val;
  logic        i_imm_valid;
  logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;
  int checks = 0;
  int failures = 0;
  tl45_register_read dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_pipe_stall(i_pipe_stall), .i_pipe_flush(i_pipe_flush),
    .o_pipe_stall(o_pipe_stall), .o_pipe_flush(o_pipe_flush),
    .i_opcode(i_opcode), .i_dr(i_dr), .i_sr1(i_sr1), .i_sr2(i_sr2),
    .i_imm(i_imm), .i_imm_valid(i_imm_valid), .i_jmp_cond(i_jmp_cond), .i_pc(i_pc),
    .i_of_reg(i_of_reg), .i_of_val(i_of_val), .i_wb_reg(i_wb_reg), .i_wb_val(i_wb_val),
    .o_opcode(o_opcode), .o_dr(o_dr), .o_jmp_cond(o_jmp_cond),
    .o_sr1_val(o_sr1_val), .o_sr2_val(o_sr2_val),
    .o_target_offset(o_target_offset), .o_pc(o_pc)
  );
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask
  task automatic idle();
    i_pipe_stall = 0; i_pipe_flush = 0; i_opcode = 0; i_dr = 0; i_sr1 = 0; i_sr2 = 0;
    i_imm = 0; i_imm_valid = 0; i_jmp_cond = 0; i_pc = 0;
    i_of_reg = 0; i_of_val = 0; i_wb_reg = 0; i_wb_val = 0;
  endtask
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_opcode"}, {27'd0, o_opcode}, 32'd0);
    check({tag, "_dr"}, {28'd0, o_dr}, 32'd0);
    check({tag, "_jmp"}, {28'd0, o_jmp_cond}, 32'd0);
    check({tag, "_sr1"}, o_sr1_val, 32'd0);
    check({tag, "_sr2"}, o_sr2_val, 32'd0);
    check({tag, "_toff"}, o_target_offset, 32'd0);
    check({tag, "_pc"}, o_pc, 32'd0);
  endtask
  initial begin
    idle();
    i_reset = 1;
    step();
    step();
    check_zero("reset");
    i_reset = 0;
    step();
    check_zero("post_release");
    // write r3, read it next cycle from the regfile
    i_wb_reg = 3; i_wb_val = 32'hDEADBEEF;
    step();
    i_wb_reg = 0; i_wb_val = 0; i_sr1 = 3; i_opcode = 2;
    step();
    check("rf_read_sr1", o_sr1_val, 32'hDEADBEEF);
    check("rf_read_op", {27'd0, o_opcode}, 32'd2);
    // same-cycle writeback bypass
    i_wb_reg = 4; i_wb_val = 32'hCAFEF00D; i_sr1 = 4; i_sr2 = 3;
    step();
    check("wb_bypass_sr1", o_sr1_val, 32'hCAFEF00D);
    check("wb_bypass_sr2", o_sr2_val, 32'hDEADBEEF);
    // ALU forward beats writeback beats regfile
    i_wb_reg = 5; i_wb_val = 1; i_sr1 = 0; i_sr2 = 0;
    step();
    i_of_reg = 5; i_of_val = 7; i_wb_reg = 5; i_wb_val = 9; i_sr1 = 5; i_sr2 = 5;
    step();
    check("fwd_sr1", o_sr1_val, 32'd7);
    check("fwd_sr2", o_sr2_val, 32'd7);
    i_imm_valid = 1; i_imm = 32'hFFFFFFF0;
    step();
    check("imm_sr2", o_sr2_val, 32'hFFFFFFF0);
    check("imm_sr1", o_sr1_val, 32'd7);
    check("imm_toff", o_target_offset, 32'hFFFFFFF0);
    i_of_reg = 0; i_of_val = 0; i_wb_reg = 0; i_wb_val = 0; i_imm_valid = 0; i_imm = 32'h10;
    step();
    check("r5_after_wb", o_sr1_val, 32'd9);
    check("toff_no_imm_valid", o_target_offset, 32'h10);
    // r0 never reads nonzero
    i_wb_reg = 0; i_wb_val = 32'h55; i_of_reg = 0; i_of_val = 32'h66; i_sr1 = 0; i_sr2 = 0;
    step();
    check("r0_sr1", o_sr1_val, 32'd0);
    check("r0_sr2", o_sr2_val, 32'd0);
    step();
    check("r0_sr1_again", o_sr1_val, 32'd0);
    // load ADD, then stall for three cycles
    idle();
    i_opcode = 1; i_dr = 2; i_pc = 32'h40; i_jmp_cond = 3; i_sr1 = 3;
    step();
    check("add_op", {27'd0, o_opcode}, 32'd1);
    check("add_dr", {28'd0, o_dr}, 32'd2);
    check("add_pc", o_pc, 32'h40);
    i_pipe_stall = 1; i_opcode = 7; i_dr = 9; i_pc = 32'h80; i_sr1 = 4; i_jmp_cond = 5;
    i_wb_reg = 3; i_wb_val = 32'h11111111;
    #1;
    check("stall_mirror", {31'd0, o_pipe_stall}, 32'd1);
    check("flush_mirror_lo", {31'd0, o_pipe_flush}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      i_wb_reg = 0;
      i_pc = i_pc + 32'h4;
      check("hold_op", {27'd0, o_opcode}, 32'd1);
      check("hold_dr", {28'd0, o_dr}, 32'd2);
      check("hold_pc", o_pc, 32'h40);
      check("hold_sr1", o_sr1_val, 32'hDEADBEEF);
      check("hold_jmp", {28'd0, o_jmp_cond}, 32'd3);
    end
    i_pipe_flush = 1;
    #1;
    check("flush_mirror", {31'd0, o_pipe_flush}, 32'd1);
    step();
    check_zero("flush");
    // writeback during stall must have landed in r3
    idle();
    i_sr1 = 3;
    #1;
    check("stall_mirror_lo", {31'd0, o_pipe_stall}, 32'd0);
    step();
    check("wb_during_stall", o_sr1_val, 32'h11111111);
    // asynchronous reset mid-run
    idle();
    i_of_reg = 6; i_of_val = 32'h1234; i_sr1 = 6; i_pc = 32'h99; i_opcode = 3;
    step();
    check("pre_reset_sr1", o_sr1_val, 32'h1234);
    idle();
    #2;
    i_reset = 1;
    #1;
    check_zero("async_reset");
    #1;
    i_reset = 0;
    i_sr1 = 3; i_sr2 = 4;
    step();
    check("rf_cleared_r3", o_sr1_val, 32'd0);
    check("rf_cleared_r4", o_sr2_val, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tl45_register_read.md
Name: tl45_register_read

Overview:
- Operand-fetch stage of the tl45 pipeline; sits between decode and the ALU stage.
- Holds the 16-entry architectural register file (r0 hardwired to zero) and resolves RAW hazards by bypassing from the ALU stage and the writeback port.
- Drives the registered operand buffer the ALU consumes: opcode, dr, jmp_cond, sr1/sr2 values, target offset, pc.
- Propagates stall and flush upstream to decode.

Parameters:
- XLEN, 32, datapath and register width.
- NREG, 16, architectural register count; index width is 4 bits, fixed.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_pipe_stall  in  1  stall from ALU stage; hold buffer
- i_pipe_flush  in  1  flush from ALU stage; clear buffer
- o_pipe_stall  out  1  stall to decode
- o_pipe_flush  out  1  flush to decode
- i_opcode  in  5  decoded opcode
- i_dr  in  4  destination register
- i_sr1, i_sr2  in  4  source register indices
- i_imm  in  XLEN  sign-extended immediate / branch offset
- i_imm_valid  in  1  1: sr2 value is replaced by i_imm
- i_jmp_cond  in  4  branch condition code
- i_pc  in  XLEN  instruction pc
- i_of_reg  in  4  ALU forward register (0 = none)
- i_of_val  in  XLEN  ALU forward value
- i_wb_reg  in  4  writeback register (0 = no write)
- i_wb_val  in  XLEN  writeback value
- o_opcode  out  5  registered opcode
- o_dr  out  4  registered destination register
- o_jmp_cond  out  4  registered condition code
- o_sr1_val, o_sr2_val  out  XLEN  registered operands
- o_target_offset  out  XLEN  registered i_imm
- o_pc  out  XLEN  registered pc

Behaviour:
- Reset (asynchronous, active-high, i_reset): all o_* buffer outputs = 0, all register-file entries = 0. Buffer outputs stay 0 on the first edge after release unless an instruction is loaded.
- Register file:
  - Write on posedge when i_wb_reg != 0; writes to r0 are ignored.
  - Writeback is NOT gated by stall or flush.
- Operand resolution (combinational, per source s in {sr1, sr2}):
  - s == 0 -> 0.
  - else s == i_of_reg -> i_of_val (ALU forward, highest priority).
  - else s == i_wb_reg -> i_wb_val (same-cycle write bypass).
  - else regfile[s].
- sr2 select: o_sr2_val source = i_imm when i_imm_valid, else resolved sr2. o_target_offset = i_imm always.
- Buffer update on posedge, in priority order:
  1. i_pipe_flush: all o_* = 0, including o_pc and o_opcode. Result is a NOP: ALU opcode 0, no write, no branch.
  2. else i_pipe_stall: all o_* hold their values.
  3. else: load all o_* from the inputs and resolved operands.
- Flush wins over simultaneous stall.
- Upstream signals: o_pipe_stall = i_pipe_stall; o_pipe_flush = i_pipe_flush; both combinational pass-through. This stage never originates stall or flush.
- Latency: one cycle from decode inputs to o_*.
- No internal FSM beyond the buffer and register file; the valid/NOP state is encoded as opcode 0 with dr 0.
- Forwarding during stall: operands are captured once at load time. A writeback during the hold does not alter held operands. This is correct because the producer had already forwarded at capture.

Test Plan:
- Reset mid-run: assert i_reset asynchronously between edges with o_sr1_val=0x1234 -> all outputs 0 immediately; regfile reads return 0 after release.
- Write/read: i_wb_reg=3, i_wb_val=0xDEADBEEF on cycle N; on cycle N+1 load sr1=3 -> o_sr1_val=0xDEADBEEF. Same-cycle case (sr1=3 while writing) -> 0xDEADBEEF via bypass.
- ALU forward priority: i_of_reg=5/i_of_val=7, i_wb_reg=5/i_wb_val=9, regfile r5=1; load sr1=sr2=5 -> both operands = 7. With i_imm_valid=1 and i_imm=0xFFFFFFF0 -> o_sr2_val=0xFFFFFFF0, o_sr1_val=7.
- r0 handling: i_wb_reg=0, i_wb_val=0x55, and i_of_reg=0 -> sr1=0 yields o_sr1_val=0; r0 unaffected.
- Stall and flush:
  - Load ADD (opcode 1, dr 2, pc 0x40).
  - Stall for 3 cycles while inputs change -> outputs held at opcode 1, dr 2, pc 0x40.
  - Assert flush and stall together -> all outputs 0 next edge.
  - o_pipe_stall and o_pipe_flush mirror their inputs in the same cycle.
